// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants, request enumerations and encoder FSM state.
// Shared by the instruction packer and the byte-streaming encoder.
package mips_isa_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    OC_R   = 2'b00,
    OC_LW  = 2'b01,
    OC_SW  = 2'b10,
    OC_BEQ = 2'b11
  } op_class_e;

  typedef enum logic [2:0] {
    AF_ADD = 3'b000,
    AF_SUB = 3'b001,
    AF_AND = 3'b010,
    AF_OR  = 3'b011,
    AF_SLT = 3'b100
  } alu_fn_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } enc_state_e;

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: abstract request to a 32-bit MIPS word.
// Flags R-type requests whose ALU function has no funct code.
module mips_instr_pack
  import mips_isa_pkg::*;
(
  input  logic [1:0]  op_class_i,
  input  logic [2:0]  alu_fn_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [5:0] funct;
  logic       bad_fn;

  always_comb begin
    funct  = FN_ADD;
    bad_fn = 1'b0;
    unique case (alu_fn_e'(alu_fn_i))
      AF_ADD:  funct = FN_ADD;
      AF_SUB:  funct = FN_SUB;
      AF_AND:  funct = FN_AND;
      AF_OR:   funct = FN_OR;
      AF_SLT:  funct = FN_SLT;
      default: bad_fn = 1'b1;
    endcase
  end

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    unique case (op_class_e'(op_class_i))
      OC_R: begin
        word_o    = {OP_R, rs_i, rt_i, rd_i,
                     5'd0, funct};
        illegal_o = bad_fn;
      end
      OC_LW:  word_o = {OP_LW, rs_i, rt_i, imm_i};
      OC_SW:  word_o = {OP_SW, rs_i, rt_i, imm_i};
      OC_BEQ: word_o = {OP_BEQ, rs_i, rt_i, imm_i};
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streams packed MIPS words MSB-first as bytes over valid/ready.
// Define INSTR_PARITY_EN to append an XOR parity byte per word.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op_class,
  input  logic [2:0]         alu_fn,
  input  logic [4:0]         rs,
  input  logic [4:0]         rt,
  input  logic [4:0]         rd,
  input  logic [15:0]        imm,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               err,
  output logic [COUNT_W-1:0] instr_count
);

`ifdef INSTR_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int SR_W = NB * 8;
  localparam logic [2:0] LAST_IDX = 3'(NB - 1);

  enc_state_e         state_q;
  logic [SR_W-1:0]    sreg_q;
  logic [SR_W-1:0]    sreg_d;
  logic [2:0]         idx_q;
  logic [COUNT_W-1:0] cnt_q;
  logic               err_q;
  logic [31:0]        word;
  logic               illegal;

  mips_instr_pack u_pack (
    .op_class_i (op_class),
    .alu_fn_i   (alu_fn),
    .rs_i       (rs),
    .rt_i       (rt),
    .rd_i       (rd),
    .imm_i      (imm),
    .word_o     (word),
    .illegal_o  (illegal)
  );

`ifdef INSTR_PARITY_EN
  assign sreg_d = {word, word[31:24] ^ word[23:16]
                       ^ word[15:8]  ^ word[7:0]};
`else
  assign sreg_d = word;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (illegal) begin
              err_q <= 1'b1;
            end else begin
              sreg_q  <= sreg_d;
              idx_q   <= '0;
              state_q <= S_SEND;
            end
          end
        end
        S_SEND: begin
          // Shifting leaves zeros behind, so IDLE shows out_byte=0
          if (out_ready) begin
            sreg_q <= sreg_q << 8;
            idx_q  <= idx_q + 3'd1;
            if (idx_q == LAST_IDX) begin
              state_q <= S_IDLE;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE) & ~rst;
  assign out_valid   = (state_q == S_SEND);
  assign out_byte    = sreg_q[SR_W-1 -: 8];
  assign out_last    = out_valid & (idx_q == LAST_IDX);
  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Inverse of the single-cycle MIPS control decoder. Accepts an abstract instruction request: class, ALU function, register fields and immediate. Packs it into a 32-bit MIPS word using the same opcode and funct encodings the decoder consumes, and streams the word out MSB-first as bytes over a valid/ready handshake. The block sits on the test/stimulus side of the control path and drives instruction bytes toward the decoder's instruction fetch.

## Interface
Parameters:
- COUNT_W, 16, width of the completed-instruction counter

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- op_class  in  2  00=R-type, 01=LW, 10=SW, 11=BEQ
- alu_fn  in  3  R-type only: 000=ADD, 001=SUB, 010=AND, 011=OR, 100=SLT; 101–111 illegal
- rs, rt, rd  in  5 each  register fields (rd used by R-type only)
- imm  in  16  immediate (LW/SW/BEQ only)
- out_byte  out  8  current instruction byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts the byte
- out_last  out  1  marks the final byte of an instruction
- err  out  1  one-cycle pulse when an illegal request is rejected
- instr_count  out  COUNT_W  number of fully transmitted instructions, wraps modulo 2^COUNT_W

## Operation
- Encodings:
  - R-type = {000000, rs, rt, rd, 00000, funct}, with funct ADD=0x20, SUB=0x22, AND=0x24, OR=0x25, SLT=0x2A.
  - LW = {100011, rs, rt, imm}.
  - SW = {101011, rs, rt, imm}.
  - BEQ = {000100, rs, rt, imm}.
- Don't-care fields: rd and alu_fn are ignored for non-R classes; imm is ignored for R-type; shamt is always 0.
- FSM states: IDLE and SEND.
  - IDLE: in_ready=1, out_valid=0.
  - IDLE, handshake (in_valid & in_ready) with a legal request: latch the packed word into a 32-bit shift register, byte index ← 0, go to SEND.
  - IDLE, handshake with an illegal request (op_class=00 and alu_fn≥101): no word is latched, err=1 on the next cycle only, stay in IDLE.
  - SEND: in_ready=0, out_valid=1, out_byte = word[31-8i -: 8] for byte index i.
  - SEND, out_valid & out_ready: index increments. out_last=1 when the index is at the final byte.
  - SEND, final-byte handshake: go to IDLE, instr_count increments.
- out_byte, out_last and the index hold stable while out_valid=1 and out_ready=0. The sink may stall indefinitely.
- Inputs are sampled only on the handshake cycle. Input changes during SEND have no effect.

## Timing
- Reset values: in_ready=1 only after reset deasserts (0 while rst=1); out_valid=0, out_byte=0, out_last=0, err=0, instr_count=0; state=IDLE.
- Latency: a request accepted at edge N gives out_valid=1 at cycle N+1 with byte 0.
- Throughput with out_ready held at 1: 4 byte cycles plus 1 IDLE cycle, i.e. 5 cycles per instruction (6 with parity enabled).
- in_ready is low for the whole of SEND; the block never accepts back-to-back requests.
- rst during SEND: the word is discarded, out_valid=0 from the next cycle, and instr_count clears.
- rst wins over a simultaneous handshake.
- instr_count wraps from 2^COUNT_W−1 to 0. err does not change instr_count.

## Configuration
- INSTR_PARITY_EN defined: a fifth byte follows the four word bytes, equal to the XOR of the four bytes. out_last moves to the fifth byte, and instr_count increments on its handshake.
- INSTR_PARITY_EN undefined: exactly 4 bytes are sent, and no parity logic exists.

## Structure
- Package mips_isa_pkg holds:
  - opcode constants (R=6'b000000, LW=6'b100011, SW=6'b101011, BEQ=6'b000100);
  - funct constants;
  - op_class and alu_fn enumerations;
  - the FSM state typedef.
- Sub-module mips_instr_pack is purely combinational. It maps (op_class, alu_fn, rs, rt, rd, imm) to {word[31:0], illegal}. The top level holds the FSM, shift register, index, counter and err logic.

## Test plan
- ADD rs=1 rt=2 rd=3, out_ready=1 → bytes 0x00,0x22,0x18,0x20 on 4 consecutive cycles starting at accept+1; out_last on 0x20; instr_count=1.
- LW rs=29 rt=8 imm=0x0004 → 0x8F,0xA8,0x00,0x04. SW rs=29 rt=9 imm=0xFFFC → 0xAF,0xA9,0xFF,0xFC.
- BEQ rs=4 rt=5 imm=3, out_ready toggled 1/0 each cycle → 0x10,0x85,0x00,0x03, each held stable while stalled; in_ready=0 throughout.
- op_class=00, alu_fn=110 → err high for exactly one cycle, out_valid stays 0, instr_count unchanged, in_ready stays 1.
- rst asserted after byte 1 of an ADD → out_valid=0 next cycle, instr_count=0; a new SLT rs=1 rt=2 rd=3 then gives 0x00,0x22,0x18,0x2A.
- INSTR_PARITY_EN defined, ADD rs=1 rt=2 rd=3 → fifth byte 0x1A with out_last; instr_count increments only after it.
